param_memory: RTL and testbench
===============================

Name: param_memory

Overview:
- Parametrised successor to the single-instance word memory used by the CPU datapath.
- Two registered read ports (instruction fetch, data load) and one write port with byte enables.
- Adds a post-reset clear sequencer, a `ready` flag, read `valid` strobes, write-first forwarding and out-of-range address detection.
- Sits between the fetch/memory stages and the backing array; consumers must wait for `ready` before issuing requests.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width of every address port.
- DEPTH, 256, number of words; must be a power of two, at least 2.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clearing and go straight to READY.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- read1_sig  input  1  port-1 read request.
- read1_address  input  ADDR_WIDTH  port-1 byte address.
- read1_out  output  DATA_WIDTH  port-1 read data, registered.
- read1_valid  output  1  read1_out holds data for the request of the previous cycle.
- read2_sig  input  1  port-2 read request.
- read2_address  input  ADDR_WIDTH  port-2 byte address.
- read2_out  output  DATA_WIDTH  port-2 read data, registered.
- read2_valid  output  1  read2_out holds data for the request of the previous cycle.
- write2_sig  input  1  write request.
- write2_address  input  ADDR_WIDTH  write byte address.
- write2_value  input  DATA_WIDTH  write data.
- write2_byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
- ready  output  1  high when requests are accepted.
- addr_err  output  1  one-cycle pulse after any accepted request carried an out-of-range address.

Behaviour:
- Address decode:
  - BL = log2(DATA_WIDTH/8); IW = log2(DEPTH).
  - Word index = address[BL+IW-1:BL]. The low BL bits are ignored, so misaligned addresses act as word-aligned.
  - An address is out of range if any bit above BL+IW-1 is nonzero.
- Reset (reset = 0, asynchronous):
  - read1_out, read2_out = 0.
  - read1_valid, read2_valid, addr_err, ready = 0.
  - FSM goes to CLEAR and the clear counter goes to 0.
  - The array contents are not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR, CLEAR_ON_RESET = 1: each cycle write 0 to array[counter] and increment the counter. When counter = DEPTH-1 the state goes to READY on that edge. Total DEPTH cycles after reset deasserts.
  - CLEAR, CLEAR_ON_RESET = 0: go to READY on the first edge after reset deasserts.
  - ready = 1 only in READY (registered state decode).
  - While ready = 0, all *_sig inputs are ignored: no write, valid stays 0, addr_err stays 0, outputs hold their value.
  - Reset asserted mid-CLEAR restarts the clear from index 0.
  - READY is left only by reset.
- Write (READY, write2_sig = 1, in range):
  - On the edge, for each byte i with write2_byte_en[i] = 1, array[idx] byte i <= write2_value byte i. Other bytes are unchanged.
  - If write2_byte_en is all zero, nothing is written.
- Read (READY, readN_sig = 1):
  - readN_out and readN_valid update on the next edge (latency 1).
  - If readN_sig = 0, readN_valid <= 0 and readN_out holds its value.
- Read during write, same index in the same cycle: write-first. The read returns the byte-merged new word (enabled bytes from write2_value, other bytes from the old word).
- Both read ports may address the same index in the same cycle; both return identical data.
- Out of range:
  - A write is suppressed.
  - A read returns 0 with valid = 1.
  - addr_err <= 1 for the next cycle if any accepted port was out of range; otherwise addr_err <= 0.

Decomposition:
- Shared package `mem_pkg`:
  - FSM state encoding (CLEAR, READY).
  - Helper function for the byte-merge of old word, new word and enables.
  - Default width constants (DATA_WIDTH, ADDR_WIDTH) shared with the CPU top.
- One sub-module is natural: `mem_addr_decode`, instantiated three times. It takes an address and outputs the word index and an out-of-range flag.
- Array, FSM, forwarding and output registers stay in param_memory.

Test Plan (DATA_WIDTH = 32, ADDR_WIDTH = 32, DEPTH = 16 unless stated):
1. Clear sequence:
   - Stimulus: hold reset = 0 for 2 cycles, release, and drive read1_sig = 1 throughout.
   - Required: ready rises exactly 16 cycles after release and read1_valid stays 0 until then.
   - After ready, reading addresses 0x0 through 0x3C returns 0 for every word.
   - Repeat with CLEAR_ON_RESET = 0: ready rises 1 cycle after release.
2. Basic write then read:
   - Stimulus: write 666 to address 0x0 with byte_en = 4'b1111; next cycle read1 at 0x0 and read2 at 0x3.
   - Required: one cycle later read1_out = 666 and read2_out = 666, both valid = 1 (0x3 aliases word 0).
3. Byte enables:
   - Stimulus: word at 0x8 = 0x11223344; write 0xAABBCCDD with byte_en = 4'b0101; then read.
   - Required: read returns 0x11BB33DD.
4. Write-first forwarding:
   - Stimulus: word at 0x4 = 0x00000000; in the same cycle write 0xDEADBEEF with byte_en = 4'b0011 and read1 at 0x4.
   - Required: read1_out = 0x0000BEEF on the next cycle.
5. Out of range:
   - Stimulus: write 0x55 to 0x40; in the same cycle read2 at 0x44.
   - Required: next cycle addr_err = 1 for exactly one cycle, read2_out = 0 with read2_valid = 1, and word 0 is unchanged (read back 666).
6. Reset mid-clear:
   - Stimulus: assert reset for 1 cycle when the clear counter = 7.
   - Required: ready falls immediately and stays 0; it rises 16 cycles after the second release; all words read 0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants, FSM encoding and byte-merge helper for
//               param_memory and the CPU top.
// Revision    : 1.0
// ============================================================================
package mem_pkg;

    localparam int c_default_data_width = 32;
    localparam int c_default_addr_width = 32;

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    // One lane of a byte-enabled merge: the enabled byte wins over the stored one.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_decode
// Description : Byte address to word index, with out-of-range detection.
// Revision    : 1.0
// ============================================================================
module mem_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_BITS  = 2,
    parameter int INDEX_BITS = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [INDEX_BITS-1:0] o_index,
    output logic                  o_out_of_range
);

    localparam int c_top = BYTE_BITS + INDEX_BITS;

    assign o_index = i_addr[c_top-1:BYTE_BITS];

    generate
        if (c_top < ADDR_WIDTH) begin : g_upper
            assign o_out_of_range = |i_addr[ADDR_WIDTH-1:c_top];
        end else begin : g_no_upper
            assign o_out_of_range = 1'b0;
        end

        // Sub-word address bits are deliberately ignored (misaligned acts aligned).
        if (BYTE_BITS > 0) begin : g_low
            logic w_unused_low;
            assign w_unused_low = ^i_addr[BYTE_BITS-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/param_memory.sv
`default_nettype none
// ============================================================================
// Module      : param_memory
// Description : Two-read / one-write word memory with byte enables, post-reset
//               clear, write-first forwarding and address range checking.
// Revision    : 1.0
// ============================================================================
module param_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = c_default_data_width,
    parameter int ADDR_WIDTH     = c_default_addr_width,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read1_sig,
    input  logic [ADDR_WIDTH-1:0]   read1_address,
    output logic [DATA_WIDTH-1:0]   read1_out,
    output logic                    read1_valid,
    input  logic                    read2_sig,
    input  logic [ADDR_WIDTH-1:0]   read2_address,
    output logic [DATA_WIDTH-1:0]   read2_out,
    output logic                    read2_valid,
    input  logic                    write2_sig,
    input  logic [ADDR_WIDTH-1:0]   write2_address,
    input  logic [DATA_WIDTH-1:0]   write2_value,
    input  logic [DATA_WIDTH/8-1:0] write2_byte_en,
    output logic                    ready,
    output logic                    addr_err
);

    localparam int c_nbytes = DATA_WIDTH / 8;
    localparam int c_bl     = $clog2(c_nbytes);
    localparam int c_iw     = $clog2(DEPTH);
    localparam logic [c_iw-1:0] c_last = c_iw'(DEPTH - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [c_iw-1:0]       r_clr_cnt;
    logic                  w_ready;
    logic                  w_clr_we;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [c_iw-1:0]       w_idx1, w_idx2, w_idxw;
    logic                  w_oor1, w_oor2, w_oorw;
    logic                  w_rd1_acc, w_rd2_acc, w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_old, w_merged;
    logic [DATA_WIDTH-1:0] w_rd1_data, w_rd2_data;

    logic [DATA_WIDTH-1:0] r_rd1_out, r_rd2_out;
    logic                  r_rd1_valid, r_rd2_valid, r_addr_err;

    mem_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_BITS(c_bl), .INDEX_BITS(c_iw)) u_dec_rd1 (
        .i_addr         (read1_address),
        .o_index        (w_idx1),
        .o_out_of_range (w_oor1)
    );

    mem_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_BITS(c_bl), .INDEX_BITS(c_iw)) u_dec_rd2 (
        .i_addr         (read2_address),
        .o_index        (w_idx2),
        .o_out_of_range (w_oor2)
    );

    mem_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_BITS(c_bl), .INDEX_BITS(c_iw)) u_dec_wr (
        .i_addr         (write2_address),
        .o_index        (w_idxw),
        .o_out_of_range (w_oorw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_clear;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_clear: begin
                if ((CLEAR_ON_RESET == 0) || (r_clr_cnt == c_last)) begin
                    w_state_next = c_st_ready;
                end
            end
            c_st_ready: w_state_next = c_st_ready;
            default:    w_state_next = c_st_clear;
        endcase
    end

    always_comb begin
        w_ready  = (r_state == c_st_ready);
        w_clr_we = (r_state == c_st_clear) && (CLEAR_ON_RESET != 0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we) begin
            r_clr_cnt <= r_clr_cnt + c_iw'(1);
        end
    end

    assign w_rd1_acc = w_ready & read1_sig;
    assign w_rd2_acc = w_ready & read2_sig;
    assign w_wr_en   = w_ready & write2_sig & ~w_oorw;
    assign w_wr_old  = r_mem[w_idxw];

    generate
        for (genvar i = 0; i < c_nbytes; i++) begin : g_byte
            assign w_merged[8*i +: 8] = merge_byte(w_wr_old[8*i +: 8],
                                                   write2_value[8*i +: 8],
                                                   write2_byte_en[i]);
        end
    endgenerate

    // Write-first: a read of the word being written sees the merged result.
    assign w_rd1_data = w_oor1 ? '0 :
                        (w_wr_en && (w_idxw == w_idx1)) ? w_merged : r_mem[w_idx1];
    assign w_rd2_data = w_oor2 ? '0 :
                        (w_wr_en && (w_idxw == w_idx2)) ? w_merged : r_mem[w_idx2];

    // An all-zero enable rewrites the old word, leaving the array unchanged.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_idxw] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd1_out   <= '0;
            r_rd2_out   <= '0;
            r_rd1_valid <= 1'b0;
            r_rd2_valid <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rd1_valid <= w_rd1_acc;
            r_rd2_valid <= w_rd2_acc;
            if (w_rd1_acc) begin
                r_rd1_out <= w_rd1_data;
            end
            if (w_rd2_acc) begin
                r_rd2_out <= w_rd2_data;
            end
            r_addr_err <= w_ready & ((read1_sig & w_oor1) |
                                     (read2_sig & w_oor2) |
                                     (write2_sig & w_oorw));
        end
    end

    assign read1_out   = r_rd1_out;
    assign read2_out   = r_rd2_out;
    assign read1_valid = r_rd1_valid;
    assign read2_valid = r_rd2_valid;
    assign addr_err    = r_addr_err;
    assign ready       = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_param_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_memory
// Description : Scoreboard bench for param_memory (DEPTH = 16) against a
//               word-array reference model.
// Revision    : 1.0
// ============================================================================
module tb_param_memory;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          read1_sig = 1'b0, read2_sig = 1'b0, write2_sig = 1'b0;
    logic [AW-1:0] read1_address = '0, read2_address = '0, write2_address = '0;
    logic [DW-1:0] write2_value = '0;
    logic [3:0]    write2_byte_en = '0;

    logic [DW-1:0] read1_out, read2_out, nc_read1_out, nc_read2_out;
    logic          read1_valid, read2_valid, ready, addr_err;
    logic          nc_read1_valid, nc_read2_valid, nc_ready, nc_addr_err;

    always #5 clk = ~clk;

    param_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .reset(reset),
        .read1_sig(read1_sig), .read1_address(read1_address),
        .read1_out(read1_out), .read1_valid(read1_valid),
        .read2_sig(read2_sig), .read2_address(read2_address),
        .read2_out(read2_out), .read2_valid(read2_valid),
        .write2_sig(write2_sig), .write2_address(write2_address),
        .write2_value(write2_value), .write2_byte_en(write2_byte_en),
        .ready(ready), .addr_err(addr_err)
    );

    param_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0)) u_dut_nc (
        .clk(clk), .reset(reset),
        .read1_sig(read1_sig), .read1_address(read1_address),
        .read1_out(nc_read1_out), .read1_valid(nc_read1_valid),
        .read2_sig(read2_sig), .read2_address(read2_address),
        .read2_out(nc_read2_out), .read2_valid(nc_read2_valid),
        .write2_sig(write2_sig), .write2_address(write2_address),
        .write2_value(write2_value), .write2_byte_en(write2_byte_en),
        .ready(nc_ready), .addr_err(nc_addr_err)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        q1[$], q2[$], qe[$];
    logic [31:0] model [DEPTH];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return a >= 32'd64;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    // Monitor: every cycle, compare strobes and data against what is due now.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   e1, e2, ee;
            exp_t t;
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            e2 = (q2.size() > 0) && (q2[0].due == cyc);
            ee = (qe.size() > 0) && (qe[0].due == cyc);
            check("read1_valid", {31'b0, read1_valid}, {31'b0, e1});
            check("read2_valid", {31'b0, read2_valid}, {31'b0, e2});
            if (e1) begin
                t = q1.pop_front();
                check("read1_out", read1_out, t.val);
            end
            if (e2) begin
                t = q2.pop_front();
                check("read2_out", read2_out, t.val);
            end
            if (ee) begin
                t = qe.pop_front();
                check("addr_err", {31'b0, addr_err}, t.val);
            end else begin
                check("addr_err_idle", {31'b0, addr_err}, 32'd0);
            end
        end
    end

    // Drive one request cycle; the model applies the write first, so same-cycle
    // reads naturally observe the merged word.
    task automatic issue(input bit r1, input logic [31:0] a1,
                         input bit r2, input logic [31:0] a2,
                         input bit w,  input logic [31:0] wa,
                         input logic [31:0] wv, input logic [3:0] be);
        exp_t e;
        read1_sig = r1; read1_address = a1;
        read2_sig = r2; read2_address = a2;
        write2_sig = w; write2_address = wa; write2_value = wv; write2_byte_en = be;
        if (w && !oor(wa)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[idx(wa)][8*b +: 8] = wv[8*b +: 8];
            end
        end
        e.due = cyc + 1;
        if (r1) begin
            e.val = oor(a1) ? 32'd0 : model[idx(a1)];
            q1.push_back(e);
        end
        if (r2) begin
            e.val = oor(a2) ? 32'd0 : model[idx(a2)];
            q2.push_back(e);
        end
        e.val = {31'b0, (r1 && oor(a1)) || (r2 && oor(a2)) || (w && oor(wa))};
        qe.push_back(e);
        @(posedge clk); #1;
        read1_sig = 1'b0; read2_sig = 1'b0; write2_sig = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Called right at a negedge release of reset; counts edges until ready.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        check({name, "_nc_ready_at_release"}, {31'b0, nc_ready}, 32'd0);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check({name, "_nc_ready_1cycle"}, {31'b0, nc_ready}, 32'd1);
        end
        read1_sig = 1'b0;
        check({name, "_ready_latency"}, n, 32'd16);
        @(posedge clk); #1;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 32'(i * 4), 1'b1, 32'(i * 4 + 2), 1'b0, 32'd0, 32'd0, 4'h0);
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        read1_sig = 1'b1;
        #2 reset = 1'b0;
        #1 mon_en = 1'b1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_read1_out", read1_out, 32'd0);
        check("rst_read2_out", read2_out, 32'd0);
        check("rst_valid", {30'b0, read1_valid, read2_valid}, 32'd0);
        check("rst_addr_err", {31'b0, addr_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready("clear");
        read_all_zero();

        // Basic write, then aliasing read on both ports
        issue(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0, 32'd666, 4'hF);
        issue(1'b1, 32'h0, 1'b1, 32'h3, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        check("t2_read1", read1_out, 32'd666);
        check("t2_read2", read2_out, 32'd666);
        idle(1);

        // Byte enables
        issue(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8, 32'h11223344, 4'hF);
        issue(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
        issue(1'b1, 32'h8, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        check("t3_byte_en", read1_out, 32'h11BB33DD);
        idle(1);

        // Write-first forwarding
        issue(1'b1, 32'h4, 1'b0, 32'd0, 1'b1, 32'h4, 32'hDEADBEEF, 4'b0011);
        @(negedge clk);
        check("t4_forward", read1_out, 32'h0000BEEF);
        idle(1);

        // Out of range on write and read in the same cycle
        issue(1'b0, 32'd0, 1'b1, 32'h44, 1'b1, 32'h40, 32'h55, 4'hF);
        @(negedge clk);
        check("t5_addr_err", {31'b0, addr_err}, 32'd1);
        check("t5_read2_zero", read2_out, 32'd0);
        check("t5_read2_valid", {31'b0, read2_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_addr_err_pulse", {31'b0, addr_err}, 32'd0);
        @(posedge clk); #1;
        issue(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        check("t5_word0_kept", read1_out, 32'd666);
        idle(1);

        // Randomized traffic, including aliasing, forwarding and range errors
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a1, a2, wa;
            a1 = ($urandom_range(0, 7) == 0) ? (32'd64 + $urandom_range(0, 4000)) : 32'($urandom_range(0, 63));
            a2 = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0040) : 32'($urandom_range(0, 63));
            wa = ($urandom_range(0, 7) == 0) ? (32'd64 + $urandom_range(0, 4000)) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a1 = wa;
            issue(1'($urandom), a1, 1'($urandom), a2, 1'($urandom), wa,
                  $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) idle(1);
        end
        idle(3);

        // Reset from READY, then again in the middle of the clear
        reset = 1'b0;
        #1;
        check("t6_ready_drop", {31'b0, ready}, 32'd0);
        check("t6_rst_read1_out", read1_out, 32'd0);
        check("t6_rst_read2_out", read2_out, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("t6_ready_mid_clear", {31'b0, ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready("reclear");
        read_all_zero();

        check("queues_drained", 32'(q1.size() + q2.size() + qe.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
